// File: rtl/snoop_pkg.sv
// Shared encodings for the snooping coherence controller: line states,
// bus operations and controller FSM states.
package snoop_pkg;

   typedef logic [2:0] coh_t;

   localparam coh_t ST_I = 3'd0;
   localparam coh_t ST_S = 3'd1;
   localparam coh_t ST_M = 3'd2;
   localparam coh_t ST_E = 3'd3;

   typedef logic [1:0] bus_op_t;

   localparam bus_op_t BUS_RD   = 2'd0;
   localparam bus_op_t BUS_RDX  = 2'd1;
   localparam bus_op_t BUS_UPGR = 2'd2;

   typedef logic [1:0] fsm_t;

   localparam fsm_t FSM_IDLE      = 2'd0;
   localparam fsm_t FSM_SNOOP     = 2'd1;
   localparam fsm_t FSM_WRITEBACK = 2'd2;
   localparam fsm_t FSM_COMPLETE  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins,
// wrapping around to requester 0.
module rr_arbiter #(
   parameter int unsigned N     = 2,
   parameter int unsigned CID_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [CID_W-1:0] ptr,
   output logic [N-1:0]     gnt_oh_c,
   output logic [CID_W-1:0] gnt_idx_c,
   output logic             gnt_any_c
);

   logic found;

   // Two passes: upper segment [ptr, N) first, then the wrapped segment [0, ptr).
   always_comb begin
      gnt_oh_c  = '0;
      gnt_idx_c = '0;
      found     = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req[i] && (i >= int'(ptr))) begin
            found       = 1'b1;
            gnt_oh_c[i] = 1'b1;
            gnt_idx_c   = CID_W'(i);
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req[i] && (i < int'(ptr))) begin
            found       = 1'b1;
            gnt_oh_c[i] = 1'b1;
            gnt_idx_c   = CID_W'(i);
         end
      end
   end

   assign gnt_any_c = |req;

endmodule

// File: rtl/snoop_coherence_ctrl.sv
// Snooping MSI/MESI coherence controller: one bus transaction at a time,
// round-robin arbitration among NUM_CACHES requesters, write-back from M owners.
module snoop_coherence_ctrl
   import snoop_pkg::*;
#(
   parameter  int unsigned NUM_CACHES = 2,
   parameter  int unsigned NUM_LINES  = 4,
   parameter  int unsigned IDX_W      = $clog2(NUM_LINES),
   parameter  int unsigned PROTOCOL   = 0,
   localparam int unsigned CID_W      = $clog2(NUM_CACHES)
) (
   input  logic                        Clock,
   input  logic                        Reset_n,
   input  logic [NUM_CACHES-1:0]       req_valid,
   input  logic [NUM_CACHES-1:0]       req_write,
   input  logic [NUM_CACHES*IDX_W-1:0] req_idx,
   output logic [NUM_CACHES-1:0]       req_ready,
   output logic                        bus_valid,
   output logic [1:0]                  bus_op,
   output logic [CID_W-1:0]            bus_src,
   output logic [IDX_W-1:0]            bus_idx,
   output logic                        wb_valid,
   output logic [CID_W-1:0]            wb_cache,
   output logic [IDX_W-1:0]            wb_idx,
   input  logic [CID_W-1:0]            q_cache,
   input  logic [IDX_W-1:0]            q_idx,
   output logic [2:0]                  q_state
);

   coh_t st_q [NUM_CACHES][NUM_LINES];
   coh_t st_d [NUM_CACHES][NUM_LINES];

   fsm_t                  fsm_q, fsm_d;
   logic [CID_W-1:0]      ptr_q, ptr_d;
   logic [CID_W-1:0]      win_q, win_d;
   logic [CID_W-1:0]      owner_q, owner_d;
   logic                  write_q, write_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  need_bus_q, need_bus_d;
   logic                  m_hit_q, m_hit_d;
   logic                  shared_q, shared_d;

   logic [NUM_CACHES-1:0] req_ready_q, req_ready_d;
   logic                  bus_valid_q, bus_valid_d;
   bus_op_t               bus_op_q, bus_op_d;
   logic [CID_W-1:0]      bus_src_q, bus_src_d;
   logic [IDX_W-1:0]      bus_idx_q, bus_idx_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [CID_W-1:0]      wb_cache_q, wb_cache_d;
   logic [IDX_W-1:0]      wb_idx_q, wb_idx_d;

   logic [NUM_CACHES-1:0] gnt_oh_c;
   logic [CID_W-1:0]      gnt_idx_c;
   logic                  gnt_any_c;

   logic [IDX_W-1:0]      cand_idx;
   logic                  cand_write;
   coh_t                  cand_r;
   logic                  cand_shared;
   logic                  cand_m;
   logic [CID_W-1:0]      cand_owner;
   logic                  cand_bus;
   bus_op_t               cand_op;

   rr_arbiter #(
      .N     (NUM_CACHES),
      .CID_W (CID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .gnt_oh_c  (gnt_oh_c),
      .gnt_idx_c (gnt_idx_c),
      .gnt_any_c (gnt_any_c)
   );

   // Classify the granted request up front so the bus broadcast is registered
   // and visible during the SNOOP cycle; states cannot change before then.
   always_comb begin
      cand_idx    = '0;
      cand_write  = |(req_write & gnt_oh_c);
      for (int i = 0; i < int'(NUM_CACHES); i++) begin
         if (gnt_oh_c[i]) cand_idx = cand_idx | req_idx[i*IDX_W +: IDX_W];
      end
      cand_r      = st_q[gnt_idx_c][cand_idx];
      cand_shared = 1'b0;
      cand_m      = 1'b0;
      cand_owner  = '0;
      for (int c = 0; c < int'(NUM_CACHES); c++) begin
         if (CID_W'(c) != gnt_idx_c) begin
            if (st_q[c][cand_idx] != ST_I) cand_shared = 1'b1;
            if (st_q[c][cand_idx] == ST_M) begin
               cand_m     = 1'b1;
               cand_owner = CID_W'(c);
            end
         end
      end
      cand_bus = 1'b0;
      cand_op  = BUS_RD;
      if (!cand_write) begin
         cand_bus = (cand_r == ST_I);
      end else if (cand_r == ST_S) begin
         cand_bus = 1'b1;
         cand_op  = BUS_UPGR;
      end else if (cand_r == ST_I) begin
         cand_bus = 1'b1;
         cand_op  = BUS_RDX;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      owner_d     = owner_q;
      write_d     = write_q;
      idx_d       = idx_q;
      need_bus_d  = need_bus_q;
      m_hit_d     = m_hit_q;
      shared_d    = shared_q;
      st_d        = st_q;
      req_ready_d = '0;
      bus_valid_d = 1'b0;
      bus_op_d    = bus_op_q;
      bus_src_d   = bus_src_q;
      bus_idx_d   = bus_idx_q;
      wb_valid_d  = 1'b0;
      wb_cache_d  = wb_cache_q;
      wb_idx_d    = wb_idx_q;

      case (fsm_q)
         FSM_IDLE: begin
            if (gnt_any_c) begin
               fsm_d      = FSM_SNOOP;
               win_d      = gnt_idx_c;
               write_d    = cand_write;
               idx_d      = cand_idx;
               need_bus_d = cand_bus;
               m_hit_d    = cand_m;
               owner_d    = cand_owner;
               shared_d   = cand_shared;
               ptr_d      = (gnt_idx_c == CID_W'(NUM_CACHES - 1)) ? '0 : gnt_idx_c + CID_W'(1);
               bus_valid_d = cand_bus;
               if (cand_bus) begin
                  bus_op_d  = cand_op;
                  bus_src_d = gnt_idx_c;
                  bus_idx_d = cand_idx;
               end
            end
         end
         FSM_SNOOP: begin
            if (need_bus_q && m_hit_q) begin
               fsm_d      = FSM_WRITEBACK;
               wb_valid_d = 1'b1;
               wb_cache_d = owner_q;
               wb_idx_d   = idx_q;
            end else begin
               fsm_d              = FSM_COMPLETE;
               req_ready_d[win_q] = 1'b1;
            end
         end
         FSM_WRITEBACK: begin
            fsm_d              = FSM_COMPLETE;
            req_ready_d[win_q] = 1'b1;
         end
         FSM_COMPLETE: begin
            fsm_d = FSM_IDLE;
            // Hits carry no bus op, so other caches are only touched on a broadcast.
            if (need_bus_q) begin
               for (int c = 0; c < int'(NUM_CACHES); c++) begin
                  if (CID_W'(c) != win_q) begin
                     if (write_q) begin
                        st_d[c][idx_q] = ST_I;
                     end else if ((st_q[c][idx_q] == ST_M) || (st_q[c][idx_q] == ST_E)) begin
                        st_d[c][idx_q] = ST_S;
                     end
                  end
               end
            end
            if (write_q) begin
               st_d[win_q][idx_q] = ST_M;
            end else if (need_bus_q) begin
               st_d[win_q][idx_q] = ((PROTOCOL == 1) && !shared_q) ? ST_E : ST_S;
            end
         end
         default: fsm_d = FSM_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int c = 0; c < int'(NUM_CACHES); c++) begin
            for (int l = 0; l < int'(NUM_LINES); l++) begin
               st_q[c][l] <= ST_I;
            end
         end
         fsm_q       <= FSM_IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         owner_q     <= '0;
         write_q     <= 1'b0;
         idx_q       <= '0;
         need_bus_q  <= 1'b0;
         m_hit_q     <= 1'b0;
         shared_q    <= 1'b0;
         req_ready_q <= '0;
         bus_valid_q <= 1'b0;
         bus_op_q    <= BUS_RD;
         bus_src_q   <= '0;
         bus_idx_q   <= '0;
         wb_valid_q  <= 1'b0;
         wb_cache_q  <= '0;
         wb_idx_q    <= '0;
      end else begin
         st_q        <= st_d;
         fsm_q       <= fsm_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         owner_q     <= owner_d;
         write_q     <= write_d;
         idx_q       <= idx_d;
         need_bus_q  <= need_bus_d;
         m_hit_q     <= m_hit_d;
         shared_q    <= shared_d;
         req_ready_q <= req_ready_d;
         bus_valid_q <= bus_valid_d;
         bus_op_q    <= bus_op_d;
         bus_src_q   <= bus_src_d;
         bus_idx_q   <= bus_idx_d;
         wb_valid_q  <= wb_valid_d;
         wb_cache_q  <= wb_cache_d;
         wb_idx_q    <= wb_idx_d;
      end
   end

   assign req_ready = req_ready_q;
   assign bus_valid = bus_valid_q;
   assign bus_op    = bus_op_q;
   assign bus_src   = bus_src_q;
   assign bus_idx   = bus_idx_q;
   assign wb_valid  = wb_valid_q;
   assign wb_cache  = wb_cache_q;
   assign wb_idx    = wb_idx_q;
   assign q_state   = st_q[q_cache][q_idx];

endmodule

// File: tb/tb_snoop_coherence_ctrl.sv
// Directed bench: a 4-cache MESI instance and a 2-cache MSI instance share one clock.
module tb_snoop_coherence_ctrl;

   localparam logic [1:0] OP_RD   = 2'd0;
   localparam logic [1:0] OP_RDX  = 2'd1;
   localparam logic [1:0] OP_UPGR = 2'd2;
   localparam int S_I = 0, S_S = 1, S_M = 2, S_E = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       m_rst_n;
   logic [3:0] m_req_valid, m_req_write, m_req_ready;
   logic [7:0] m_req_idx;
   logic       m_bus_valid, m_wb_valid;
   logic [1:0] m_bus_op, m_bus_src, m_bus_idx, m_wb_cache, m_wb_idx;
   logic [1:0] m_q_cache, m_q_idx;
   logic [2:0] m_q_state;

   logic       s_rst_n;
   logic [1:0] s_req_valid, s_req_write, s_req_ready;
   logic [3:0] s_req_idx;
   logic       s_bus_valid, s_wb_valid;
   logic [1:0] s_bus_op, s_bus_idx, s_wb_idx, s_q_idx;
   logic [0:0] s_bus_src, s_wb_cache, s_q_cache;
   logic [2:0] s_q_state;

   snoop_coherence_ctrl #(.NUM_CACHES(4), .NUM_LINES(4), .PROTOCOL(1)) u_mesi (
      .Clock(clk), .Reset_n(m_rst_n),
      .req_valid(m_req_valid), .req_write(m_req_write), .req_idx(m_req_idx),
      .req_ready(m_req_ready),
      .bus_valid(m_bus_valid), .bus_op(m_bus_op), .bus_src(m_bus_src), .bus_idx(m_bus_idx),
      .wb_valid(m_wb_valid), .wb_cache(m_wb_cache), .wb_idx(m_wb_idx),
      .q_cache(m_q_cache), .q_idx(m_q_idx), .q_state(m_q_state)
   );

   snoop_coherence_ctrl #(.NUM_CACHES(2), .NUM_LINES(4), .PROTOCOL(0)) u_msi (
      .Clock(clk), .Reset_n(s_rst_n),
      .req_valid(s_req_valid), .req_write(s_req_write), .req_idx(s_req_idx),
      .req_ready(s_req_ready),
      .bus_valid(s_bus_valid), .bus_op(s_bus_op), .bus_src(s_bus_src), .bus_idx(s_bus_idx),
      .wb_valid(s_wb_valid), .wb_cache(s_wb_cache), .wb_idx(s_wb_idx),
      .q_cache(s_q_cache), .q_idx(s_q_idx), .q_state(s_q_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_q(input int c, input int idx, input int exp, input string tag);
      m_q_cache = 2'(c);
      m_q_idx   = 2'(idx);
      #1;
      chk(tag, 32'(m_q_state), 32'(exp));
   endtask

   task automatic s_q(input int c, input int idx, input int exp, input string tag);
      s_q_cache = 1'(c);
      s_q_idx   = 2'(idx);
      #1;
      chk(tag, 32'(s_q_state), 32'(exp));
   endtask

   // One MESI-instance transaction, checked cycle by cycle from the SNOOP cycle.
   task automatic m_txn(input int c, input logic w, input int idx, input logic drop,
                        input logic exp_bus, input logic [1:0] exp_op,
                        input logic exp_wb, input int exp_wbc);
      @(negedge clk);
      m_req_valid[2'(c)]   = 1'b1;
      m_req_write[2'(c)]   = w;
      m_req_idx[c*2 +: 2]  = 2'(idx);
      @(negedge clk);
      if (drop) m_req_valid[2'(c)] = 1'b0;
      chk("m_bus_valid", 32'(m_bus_valid), 32'(exp_bus));
      if (exp_bus) begin
         chk("m_bus_op",  32'(m_bus_op),  32'(exp_op));
         chk("m_bus_src", 32'(m_bus_src), 32'(c));
         chk("m_bus_idx", 32'(m_bus_idx), 32'(idx));
      end
      chk("m_ready_snoop", 32'(m_req_ready), 32'(0));
      if (exp_wb) begin
         @(negedge clk);
         chk("m_wb_valid", 32'(m_wb_valid), 32'(1));
         chk("m_wb_cache", 32'(m_wb_cache), 32'(exp_wbc));
         chk("m_wb_idx",   32'(m_wb_idx),   32'(idx));
         chk("m_ready_wb", 32'(m_req_ready), 32'(0));
      end
      @(negedge clk);
      chk("m_ready", 32'(m_req_ready), 32'(1 << c));
      chk("m_wb_off", 32'(m_wb_valid), 32'(0));
      m_req_valid[2'(c)] = 1'b0;
      @(negedge clk);
      chk("m_ready_pulse", 32'(m_req_ready), 32'(0));
   endtask

   task automatic s_txn(input int c, input logic w, input int idx, input logic [1:0] exp_op);
      @(negedge clk);
      s_req_valid[1'(c)]  = 1'b1;
      s_req_write[1'(c)]  = w;
      s_req_idx[c*2 +: 2] = 2'(idx);
      @(negedge clk);
      chk("s_bus_valid", 32'(s_bus_valid), 32'(1));
      chk("s_bus_op",    32'(s_bus_op),    32'(exp_op));
      @(negedge clk);
      chk("s_ready", 32'(s_req_ready), 32'(1 << c));
      s_req_valid[1'(c)] = 1'b0;
      @(negedge clk);
      chk("s_ready_pulse", 32'(s_req_ready), 32'(0));
   endtask

   initial begin
      m_rst_n = 1'b0; s_rst_n = 1'b0;
      m_req_valid = '0; m_req_write = '0; m_req_idx = '0; m_q_cache = '0; m_q_idx = '0;
      s_req_valid = '0; s_req_write = '0; s_req_idx = '0; s_q_cache = '0; s_q_idx = '0;
      repeat (2) @(negedge clk);

      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 4; i++) m_q(c, i, S_I, "m_rst_state");
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 4; i++) s_q(c, i, S_I, "s_rst_state");
      chk("rst_ready",    32'(m_req_ready), 32'(0));
      chk("rst_bus",      32'(m_bus_valid), 32'(0));
      chk("rst_wb",       32'(m_wb_valid),  32'(0));
      chk("rst_bus_flds", 32'({m_bus_op, m_bus_src, m_bus_idx}), 32'(0));
      chk("rst_wb_flds",  32'({m_wb_cache, m_wb_idx}), 32'(0));
      chk("rst_s_outs",   32'({s_req_ready, s_bus_valid, s_wb_valid}), 32'(0));
      @(negedge clk);
      m_rst_n = 1'b1; s_rst_n = 1'b1;

      // MESI: exclusive read miss, then silent upgrade
      m_txn(0, 1'b0, 1, 1'b0, 1'b1, OP_RD, 1'b0, 0);
      m_q(0, 1, S_E, "mesi_rd_excl");
      m_txn(0, 1'b1, 1, 1'b0, 1'b0, OP_RD, 1'b0, 0);
      m_q(0, 1, S_M, "mesi_silent_upg");

      // Read of a line Modified elsewhere forces a write-back
      m_txn(0, 1'b1, 2, 1'b0, 1'b1, OP_RDX, 1'b0, 0);
      m_q(0, 2, S_M, "rdx_to_m");
      m_txn(1, 1'b0, 2, 1'b0, 1'b1, OP_RD, 1'b1, 0);
      m_q(0, 2, S_S, "wb_owner_s");
      m_q(1, 2, S_S, "wb_reader_s");

      // E demoted to S by another reader, then upgrade invalidates the sharer
      m_txn(0, 1'b0, 3, 1'b0, 1'b1, OP_RD, 1'b0, 0);
      m_txn(1, 1'b0, 3, 1'b0, 1'b1, OP_RD, 1'b0, 0);
      m_q(0, 3, S_S, "e_to_s");
      m_q(1, 3, S_S, "shared_rd_s");
      m_txn(1, 1'b1, 3, 1'b0, 1'b1, OP_UPGR, 1'b0, 0);
      m_q(1, 3, S_M, "upgr_m");
      m_q(0, 3, S_I, "upgr_inval");

      // Cache 2 reads a line Modified in cache 0
      m_txn(2, 1'b0, 1, 1'b0, 1'b1, OP_RD, 1'b1, 0);
      m_q(0, 1, S_S, "c2_wb_owner_s");
      m_q(2, 1, S_S, "c2_reader_s");

      // Round robin from a fresh reset with all requests held high
      @(negedge clk); m_rst_n = 1'b0;
      @(negedge clk); m_rst_n = 1'b1;
      m_req_valid = 4'hF; m_req_write = 4'h0; m_req_idx = 8'h00;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         chk("rr_ready", 32'(m_req_ready), (k % 3 == 2) ? 32'(1 << ((k / 3) % 4)) : 32'(0));
         chk("rr_bus", 32'(m_bus_valid), (k % 3 == 1 && k < 13) ? 32'(1) : 32'(0));
      end
      m_req_valid = 4'h0;
      m_q(0, 0, S_S, "rr_c0_s");
      m_q(3, 0, S_S, "rr_c3_s");

      // Request dropped right after acceptance still completes
      m_txn(1, 1'b1, 0, 1'b1, 1'b1, OP_UPGR, 1'b0, 0);
      m_q(1, 0, S_M, "drop_m");
      m_q(0, 0, S_I, "drop_inval");

      // MSI: read miss yields S, never E
      s_txn(0, 1'b0, 1, OP_RD);
      s_q(0, 1, S_S, "msi_rd_s");
      s_txn(0, 1'b1, 2, OP_RDX);
      s_q(0, 2, S_M, "msi_wr_m");

      // Reset asserted during the write-back cycle
      @(negedge clk);
      s_req_valid[1] = 1'b1; s_req_write[1] = 1'b0; s_req_idx[3:2] = 2'd2;
      @(negedge clk);
      chk("msi_wb_bus", 32'({s_bus_valid, s_bus_op}), 32'({1'b1, OP_RD}));
      @(negedge clk);
      chk("msi_wb_on", 32'(s_wb_valid), 32'(1));
      s_rst_n = 1'b0;
      #1;
      chk("rst_wb_drop", 32'(s_wb_valid), 32'(0));
      chk("rst_no_ready", 32'(s_req_ready), 32'(0));
      s_q(0, 2, S_I, "rst_mid_i0");
      s_q(0, 1, S_I, "rst_mid_i1");
      s_req_valid = '0;
      @(negedge clk); s_rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_ready", 32'({s_req_ready, s_wb_valid, s_bus_valid}), 32'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
